// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 types and constants (S-memory geometry, key
//                schedule state encoding, small elaboration helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // S-box geometry
    localparam int S_DEPTH  = 256;
    localparam int S_ADDR_W = 8;
    localparam int BYTE_W   = 8;

    // Key-schedule controller states
    typedef enum logic [2:0] {
        KS_IDLE      = 3'd0,
        KS_WAIT_SI   = 3'd1,
        KS_WAIT_SJ   = 3'd2,
        KS_WAIT_WR_I = 3'd3,
        KS_WAIT_WR_J = 3'd4,
        KS_DONE      = 3'd5
    } ks_state_t;

    // Width of a counter able to index n items (never less than 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/rc4_key_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_key_byte_sel
//  Description : Picks key byte number i_key_idx out of the latched key.
//                Byte 0 sits in the most significant position of the key.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter  int KEY_BYTES = 3,
    localparam int KEY_W     = BYTE_W * KEY_BYTES,
    localparam int IDX_W     = idx_width(KEY_BYTES)
)(
    input  logic [KEY_W-1:0]  i_key_q,
    input  logic [IDX_W-1:0]  i_key_idx,
    output logic [BYTE_W-1:0] o_byte
);

    // Plain mux over the key bytes; an out-of-range index yields zero
    always_comb begin
        o_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (i_key_idx == IDX_W'(k)) begin
                o_byte = i_key_q[KEY_W-1-BYTE_W*k -: BYTE_W];
            end
        end
    end

endmodule : rc4_key_byte_sel
`default_nettype wire

// File: rtl/rc4_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_key_schedule
//  Description : RC4 key-scheduling loop. For i = 0..255 computes
//                j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i]/S[j]
//                in place through a strobe/done S-memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_schedule
    import rc4_pkg::*;
#(
    parameter  int KEY_BYTES = 3,
    localparam int KEY_W     = 8 * KEY_BYTES
)(
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    input  logic [KEY_W-1:0]    secret_key,
    output logic                finish,
    output logic                busy,
    output logic                wr_start,
    output logic [S_ADDR_W-1:0] addr_out,
    output logic [BYTE_W-1:0]   wr_data_out,
    input  logic                wr_done,
    output logic                rd_start,
    input  logic                rd_done,
    input  logic [BYTE_W-1:0]   rd_data_in
);

    localparam int                  IDX_W      = idx_width(KEY_BYTES);
    localparam logic [IDX_W-1:0]    c_LAST_IDX = IDX_W'(KEY_BYTES - 1);
    localparam logic [S_ADDR_W-1:0] c_LAST_I   = S_ADDR_W'(S_DEPTH - 1);

    ks_state_t           r_state;
    logic [KEY_W-1:0]    r_key_q;
    logic [S_ADDR_W-1:0] r_i;
    logic [S_ADDR_W-1:0] r_j;
    logic [IDX_W-1:0]    r_key_idx;
    logic [BYTE_W-1:0]   r_s_i;

    logic [BYTE_W-1:0]   w_key_byte;
    logic [S_ADDR_W-1:0] w_j_next;
    logic [S_ADDR_W-1:0] w_i_next;
    logic [IDX_W-1:0]    w_key_idx_next;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_byte_sel (
        .i_key_q   (r_key_q),
        .i_key_idx (r_key_idx),
        .o_byte    (w_key_byte)
    );

    // New j from the S[i] value arriving on the read port; 8-bit wrap is the mod 256
    assign w_j_next       = r_j + rd_data_in + w_key_byte;
    assign w_i_next       = r_i + 1'b1;
    // Key index wraps at KEY_BYTES without any modulo hardware
    assign w_key_idx_next = (r_key_idx == c_LAST_IDX) ? '0 : r_key_idx + 1'b1;

    // Controller FSM and datapath; all outputs registered, strobes default low
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= KS_IDLE;
            r_key_q     <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_key_idx   <= '0;
            r_s_i       <= '0;
            finish      <= 1'b0;
            busy        <= 1'b0;
            wr_start    <= 1'b0;
            rd_start    <= 1'b0;
            addr_out    <= '0;
            wr_data_out <= '0;
        end else begin
            rd_start <= 1'b0;
            wr_start <= 1'b0;
            finish   <= 1'b0;

            case (r_state)
                KS_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_key_q   <= secret_key;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_key_idx <= '0;
                        addr_out  <= '0;
                        rd_start  <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= KS_WAIT_SI;
                    end
                end

                KS_WAIT_SI: begin
                    if (rd_done) begin
                        r_s_i    <= rd_data_in;
                        r_j      <= w_j_next;
                        addr_out <= w_j_next;
                        rd_start <= 1'b1;
                        r_state  <= KS_WAIT_SJ;
                    end
                end

                KS_WAIT_SJ: begin
                    // S[j] goes to address i; i == j needs no special case
                    if (rd_done) begin
                        addr_out    <= r_i;
                        wr_data_out <= rd_data_in;
                        wr_start    <= 1'b1;
                        r_state     <= KS_WAIT_WR_I;
                    end
                end

                KS_WAIT_WR_I: begin
                    if (wr_done) begin
                        addr_out    <= r_j;
                        wr_data_out <= r_s_i;
                        wr_start    <= 1'b1;
                        r_state     <= KS_WAIT_WR_J;
                    end
                end

                KS_WAIT_WR_J: begin
                    if (wr_done) begin
                        if (r_i == c_LAST_I) begin
                            finish  <= 1'b1;
                            r_state <= KS_DONE;
                        end else begin
                            r_i       <= w_i_next;
                            r_key_idx <= w_key_idx_next;
                            addr_out  <= w_i_next;
                            rd_start  <= 1'b1;
                            r_state   <= KS_WAIT_SI;
                        end
                    end
                end

                KS_DONE: begin
                    // finish was raised on entry and drops here
                    busy    <= 1'b0;
                    r_state <= KS_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= KS_IDLE;
                end
            endcase
        end
    end

endmodule : rc4_key_schedule
`default_nettype wire

// File: tb/tb_rc4_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_key_schedule
//  Description : Directed self-checking bench for rc4_key_schedule with a
//                behavioural S-memory (fixed or random response delay) and a
//                software KSA reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_key_schedule;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [23:0] secret_key;
    logic        finish;
    logic        busy;
    logic        wr_start;
    logic [7:0]  addr_out;
    logic [7:0]  wr_data_out;
    logic        wr_done    = 1'b0;
    logic        rd_start;
    logic        rd_done    = 1'b0;
    logic [7:0]  rd_data_in = 8'h00;

    rc4_key_schedule #(.KEY_BYTES(3)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .secret_key  (secret_key),
        .finish      (finish),
        .busy        (busy),
        .wr_start    (wr_start),
        .addr_out    (addr_out),
        .wr_data_out (wr_data_out),
        .wr_done     (wr_done),
        .rd_start    (rd_start),
        .rd_done     (rd_done),
        .rd_data_in  (rd_data_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- S-memory model ----------------
    logic [7:0] mem   [0:255];
    logic [7:0] exp_s [0:255];
    logic [7:0] ref_s [0:255];
    logic       mem_init  = 1'b0;
    logic       rand_mode = 1'b0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic [7:0] rd_a, wr_a, wr_d;

    function automatic int mem_delay();
        return rand_mode ? int'($urandom_range(5, 1)) : 1;
    endfunction

    // Memory answers after mem_delay() cycles counted from the strobe cycle
    always @(posedge clk) begin
        rd_done <= 1'b0;
        wr_done <= 1'b0;
        if (mem_init)
            for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        if (!nreset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (rd_start) begin rd_a = addr_out; rd_cnt = mem_delay(); end
            if (wr_start) begin wr_a = addr_out; wr_d = wr_data_out; wr_cnt = mem_delay(); end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin rd_done <= 1'b1; rd_data_in <= mem[rd_a]; end
            end
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) begin mem[wr_a] = wr_d; wr_done <= 1'b1; end
            end
        end
    end

    // ---------------- access log and strobe-width monitor ----------------
    logic       log_clr = 1'b0;
    int         log_n   = 0;
    logic [16:0] log_e [0:15];   // {is_write, addr, data}
    int         wide_n  = 0;
    logic       prev_rd = 1'b0, prev_wr = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (log_clr) log_n = 0;
        if (rd_start && log_n < 16) begin log_e[log_n] = {1'b0, addr_out, 8'h00}; log_n++; end
        if (wr_start && log_n < 16) begin log_e[log_n] = {1'b1, addr_out, wr_data_out}; log_n++; end
        if ((rd_start && prev_rd) || (wr_start && prev_wr)) wide_n++;
        prev_rd = rd_start;
        prev_wr = wr_start;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input int k, input logic w,
                           input logic [7:0] a, input logic [7:0] d);
        check(tag, {15'd0, log_e[k]}, {15'd0, w, a, (w ? d : 8'h00)});
    endtask

    task automatic model_identity();
        for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    endtask

    // Reference KSA applied in place to exp_s
    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] j, t, kb;
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(key >> (8 * (2 - (i % 3))));
            j  = j + exp_s[i] + kb;
            t  = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic check_s(input string tag);
        int mism;
        mism = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) mism++;
        check(tag, mism, 0);
    endtask

    task automatic mem_reinit();
        @(negedge clk); mem_init = 1'b1;
        @(negedge clk); mem_init = 1'b0;
    endtask

    // start is sampled on the posedge between the two negedges (edge 0)
    task automatic launch(input logic [23:0] key);
        @(negedge clk); log_clr = 1'b1; secret_key = key; start = 1'b1;
        @(negedge clk); log_clr = 1'b0; start = 1'b0;
    endtask

    // Counts edges after the sampling edge until finish is seen
    task automatic wait_finish(input int repulse, input logic [23:0] key2, output int lat);
        lat = 0;
        while (lat < 20000) begin
            @(posedge clk); #1;
            lat++;
            if (lat == repulse) begin start = 1'b1; secret_key = key2; end
            if (lat == repulse + 1) start = 1'b0;
            if (finish) break;
        end
        check("finish_seen", finish, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, wcnt;
        nreset = 1'b0; start = 1'b0; secret_key = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   busy,        1'b0);
        check("rst_finish", finish,      1'b0);
        check("rst_rd",     rd_start,    1'b0);
        check("rst_wr",     wr_start,    1'b0);
        check("rst_addr",   addr_out,    8'h00);
        check("rst_wdata",  wr_data_out, 8'h00);
        @(negedge clk); nreset = 1'b1;

        // Key 000000, single-cycle memory
        mem_reinit();
        launch(24'h000000);
        check("k0_busy", busy, 1'b1);
        wait_finish(-10, 24'h0, lat);
        check("k0_latency", lat, 2048);
        chk_acc("k0_a0", 0, 1'b0, 8'd0, 8'd0);
        chk_acc("k0_a1", 1, 1'b0, 8'd0, 8'd0);
        chk_acc("k0_a2", 2, 1'b1, 8'd0, 8'd0);
        chk_acc("k0_a3", 3, 1'b1, 8'd0, 8'd0);
        chk_acc("k0_a9", 9, 1'b0, 8'd3, 8'd0);
        chk_acc("k0_a10", 10, 1'b1, 8'd2, 8'd3);
        chk_acc("k0_a11", 11, 1'b1, 8'd3, 8'd2);
        model_identity(); ksa_model(24'h000000);
        check_s("k0_sbox");
        @(posedge clk); #1;
        check("k0_idle_busy",   busy,   1'b0);
        check("k0_idle_finish", finish, 1'b0);

        // Key 010203
        mem_reinit();
        launch(24'h010203);
        wait_finish(-10, 24'h0, lat);
        chk_acc("k1_a1", 1, 1'b0, 8'd1, 8'd0);
        chk_acc("k1_a2", 2, 1'b1, 8'd0, 8'd1);
        chk_acc("k1_a3", 3, 1'b1, 8'd1, 8'd0);
        chk_acc("k1_a5", 5, 1'b0, 8'd3, 8'd0);
        chk_acc("k1_a6", 6, 1'b1, 8'd1, 8'd3);
        chk_acc("k1_a7", 7, 1'b1, 8'd3, 8'd0);
        model_identity(); ksa_model(24'h010203);
        check_s("k1_sbox");

        // Key A5C37E: zero-wait reference, then random delays with a stray start
        mem_reinit();
        launch(24'hA5C37E);
        wait_finish(-10, 24'h0, lat);
        for (int k = 0; k < 256; k++) ref_s[k] = mem[k];
        model_identity(); ksa_model(24'hA5C37E);
        check_s("a5_zero_sbox");
        rand_mode = 1'b1;
        mem_reinit();
        launch(24'hA5C37E);
        wait_finish(500, 24'h123456, lat);
        rand_mode = 1'b0;
        wcnt = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) wcnt++;
        check("a5_rand_vs_zero", wcnt, 0);
        check_s("a5_rand_sbox");
        check("strobe_width", wide_n, 0);

        // Key FFFFFF: j wraps every step
        mem_reinit();
        launch(24'hFFFFFF);
        wait_finish(-10, 24'h0, lat);
        chk_acc("ff_a1", 1, 1'b0, 8'd255, 8'd0);
        chk_acc("ff_a2", 2, 1'b1, 8'd0, 8'd255);
        chk_acc("ff_a6", 6, 1'b1, 8'd1, 8'd0);
        chk_acc("ff_a7", 7, 1'b1, 8'd255, 8'd1);
        chk_acc("ff_a9", 9, 1'b0, 8'd0, 8'd0);
        chk_acc("ff_a11", 11, 1'b1, 8'd0, 8'd2);
        chk_acc("ff_a14", 14, 1'b1, 8'd3, 8'd255);
        chk_acc("ff_a15", 15, 1'b1, 8'd2, 8'd3);
        model_identity(); ksa_model(24'hFFFFFF);
        check_s("ff_sbox");

        // Asynchronous reset during WAIT_WR_I at i = 100
        mem_reinit();
        launch(24'h5A17C3);
        wcnt = 0;
        for (int c = 0; c < 5000 && wcnt < 201; c++) begin
            @(posedge clk); #1;
            if (wr_start) wcnt++;
        end
        check("mid_wr_count", wcnt, 201);
        check("mid_addr", addr_out, 8'd100);
        check("mid_busy", busy, 1'b1);
        #1 nreset = 1'b0;
        #1;
        check("arst_busy",   busy,     1'b0);
        check("arst_wr",     wr_start, 1'b0);
        check("arst_rd",     rd_start, 1'b0);
        check("arst_finish", finish,   1'b0);
        check("arst_addr",   addr_out, 8'h00);
        @(negedge clk); @(negedge clk); nreset = 1'b1;
        mem_reinit();
        launch(24'h5A17C3);
        wait_finish(-10, 24'h0, lat);
        check("rerun_latency", lat, 2048);
        model_identity(); ksa_model(24'h5A17C3);
        check_s("rerun_sbox");

        // Back-to-back: second start one cycle after finish, on the permuted S
        mem_reinit();
        launch(24'h3C9E01);
        wait_finish(-10, 24'h0, lat);
        @(posedge clk); #1;
        start = 1'b1; secret_key = 24'hB7004F;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        wait_finish(-10, 24'h0, lat);
        check("b2b_latency", lat, 2048);
        model_identity(); ksa_model(24'h3C9E01); ksa_model(24'hB7004F);
        check_s("b2b_sbox");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rc4_key_schedule
`default_nettype wire

// File: doc/rc4_key_schedule.md
Name: rc4_key_schedule

Overview:
RC4 key-scheduling stage (second loop). It runs j = j + s[i] + key[i mod KEY_BYTES] and swaps s[i] with s[j] for i = 0..255, in place in the shared S-memory.
It sits directly upstream of the RC4 decrypt stage. It runs after S has been initialised to the identity, and its finish pulse is what allows decryption to start.
It uses the same start/done strobe handshake on S-memory as the decrypt stage.

Parameters:
KEY_BYTES, 3, number of secret-key bytes; key schedule repeats with this period.
KEY_W, 8*KEY_BYTES, secret key width (derived; do not override).

Ports:
clk  input  1  system clock; all logic on rising edge
nreset  input  1  asynchronous active-low reset
start  input  1  begin schedule; sampled only in IDLE
secret_key  input  KEY_W  key; byte 0 = secret_key[KEY_W-1:KEY_W-8] (MSB first)
finish  output  1  one-cycle pulse when all 256 swaps have completed
busy  output  1  high in every non-IDLE state
wr_start  output  1  one-cycle S-memory write strobe
addr_out  output  8  S-memory address (shared by read and write)
wr_data_out  output  8  S-memory write data
wr_done  input  1  write complete
rd_start  output  1  one-cycle S-memory read strobe
rd_done  input  1  read complete; rd_data_in valid in the same cycle
rd_data_in  input  8  S-memory read data

Behaviour:
Reset:
- Asynchronous and active-low. Every register clears immediately on reset.
- After reset: state = IDLE, and all outputs, i, j, key_idx and s_i are 0.

Strobes and memory requirements:
- rd_start and wr_start default to 0 every cycle and are asserted for exactly one cycle.
- The memory must not assert done in the same cycle as the strobe. Done may arrive any number of cycles later.

State machine:
- IDLE: start=1 does the following:
  - latch secret_key into key_q; i=0, j=0, key_idx=0;
  - addr_out=0, rd_start=1;
  - go to WAIT_SI.
  - start while not in IDLE is ignored.
- WAIT_SI: on rd_done:
  - s_i <= rd_data_in;
  - j <= j + rd_data_in + key_q byte[key_idx], computed mod 256 (8-bit wrap);
  - addr_out <= that same new j; rd_start=1;
  - go to WAIT_SJ.
- WAIT_SJ: on rd_done: addr_out <= i, wr_data_out <= rd_data_in, wr_start=1, go to WAIT_WR_I.
- WAIT_WR_I: on wr_done: addr_out <= j, wr_data_out <= s_i, wr_start=1, go to WAIT_WR_J.
- WAIT_WR_J: on wr_done:
  - if i == 255, go to DONE;
  - otherwise i <= i+1, key_idx <= (key_idx == KEY_BYTES-1) ? 0 : key_idx+1, addr_out <= i+1, rd_start=1, go to WAIT_SI.
- DONE: finish=1 for one cycle, then IDLE. busy is also high in DONE.

Boundary conditions:
- i == j: both writes still occur, to the same address with the same value. Net result is unchanged S. No special-casing.
- key_idx is a wrapping counter; no divider or modulo hardware.
- i is 8 bits and terminates at 255; it never wraps back to 0 mid-run.
- secret_key changes during a run have no effect (key_q was latched at start).

Latency:
- Each access takes 2 cycles when memory answers 1 cycle after the strobe.
- A run is 1024 accesses. finish goes high exactly 2048 cycles after the edge that samples start.
- Memory wait cycles add 1:1.

Reset mid-run: abort immediately, return to IDLE. S-memory is left partially permuted; the controller must re-initialise S before the next start.

Decomposition:
- Shared package rc4_pkg holds the following, to be reused by the decrypt stage and top-level controller:
  - state enum typedef ks_state_t;
  - S_DEPTH = 256;
  - S_ADDR_W = 8;
  - BYTE_W = 8.
- The key-byte selector (key_q, key_idx → byte) is a natural small sub-module, rc4_key_byte_sel.
- The FSM and datapath stay in one module.

Test Plan:
- Identity S, key 0x000000, 1-cycle memory:
  - i=0: read addr 0, read addr 0, write (0,0), write (0,0);
  - i=2: write (2,3) then (3,2);
  - final S matches software KSA; finish at cycle 2048.
- Identity S, key 0x010203: first iteration is j=1, write (0,1) then (1,0). Second is i=1, s[1]=0, j=1+0+2=3, write (1,3) then (3,0). Full result matches the model.
- Random 1–5 cycle rd_done/wr_done delays, key 0xA5C37E:
  - final S identical to the zero-wait run;
  - strobes are never wider than one cycle;
  - start re-pulsed mid-run is ignored.
- Key-wrap and j-overflow check: key 0xFFFFFF. j wraps mod 256, key_idx sequence is 0,1,2,0,…, and the final S matches the model.
- nreset asserted during WAIT_WR_I at i=100:
  - busy, strobes and finish drop asynchronously;
  - after release and a fresh start with re-initialised S, the result matches the model.
- Back-to-back runs: second start issued one cycle after finish. It is accepted from IDLE and produces a correct second schedule.
